// File: rtl/mmap_pkg.sv
// Shared definitions for the peripheral register bank: bus FSM states and
// software-visible register addresses.
package mmap_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        ACCESS = S_ACCESS,
        DONE   = S_DONE
    } state_t;

    localparam logic [15:0] ADDR_STATS_EN = 16'hC00B;
    localparam logic [15:0] ADDR_BR_CNT   = 16'hC010;
    localparam logic [15:0] ADDR_LFSR     = 16'hC016;
    localparam logic [15:0] ADDR_RD_LO    = ADDR_BR_CNT;
    localparam logic [15:0] ADDR_RD_HI    = ADDR_LFSR;

    function automatic logic in_rd_window(input logic [15:0] addr);
        return (addr >= ADDR_RD_LO) && (addr <= ADDR_RD_HI);
    endfunction

endpackage

// File: rtl/mmap_rr_arb.sv
// Two-way round-robin arbiter; index 0 = cpu, 1 = dbg.
module mmap_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_gnt
);

    logic r_last;

    always_comb begin
        o_gnt = '0;
        if (i_adv) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
                default: o_gnt = '0;
            endcase
        end
    end

    // Pointer resets to dbg so cpu wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/mmap_bus_ctrl.sv
// Three-phase sequencer sharing the peripheral bank bus between the cpu and
// debug requesters.
module mmap_bus_ctrl
    import mmap_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_done,
    output logic [15:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_done,
    output logic [15:0] dbg_rdata,
    output logic        mm_re,
    output logic [15:0] mm_addr,
    inout  wire  [15:0] databus,
    output logic        br_stats_wr,
    output logic        lfsr_load
);

    state_t      r_state;
    logic        r_we;
    logic        r_sel;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_dbg_rdata;

    logic [1:0]  w_gnt;
    logic        w_adv;
    logic        w_access;
    logic        w_rd_hit;
    logic        w_bus_oe;

    // Grants are suppressed while reset is asserted so nothing is latched.
    assign w_adv    = rst_n && (r_state == IDLE);
    assign w_access = (r_state == ACCESS);
    assign w_rd_hit = in_rd_window(r_addr);
    assign w_bus_oe = w_access && r_we;

    mmap_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req ({dbg_req, cpu_req}),
        .i_adv (w_adv),
        .o_gnt (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_sel       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_sel   <= w_gnt[1];
                        r_we    <= w_gnt[1] ? dbg_we    : cpu_we;
                        r_addr  <= w_gnt[1] ? dbg_addr  : cpu_addr;
                        r_wdata <= w_gnt[1] ? dbg_wdata : cpu_wdata;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_state <= DONE;
                    if (!r_we) begin
                        if (r_sel) r_dbg_rdata <= w_rd_hit ? databus : '0;
                        else       r_cpu_rdata <= w_rd_hit ? databus : '0;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu_gnt     = w_gnt[0];
    assign dbg_gnt     = w_gnt[1];
    assign cpu_done    = (r_state == DONE) && !r_sel;
    assign dbg_done    = (r_state == DONE) && r_sel;
    assign cpu_rdata   = r_cpu_rdata;
    assign dbg_rdata   = r_dbg_rdata;
    assign mm_addr     = w_access ? r_addr : '0;
    assign mm_re       = w_access && !r_we && w_rd_hit;
    assign br_stats_wr = w_bus_oe && (r_addr == ADDR_STATS_EN);
    assign lfsr_load   = w_bus_oe && (r_addr == ADDR_LFSR);
    assign databus     = w_bus_oe ? r_wdata : 16'hzzzz;

endmodule

// File: tb/tb_mmap_bus_ctrl.sv
// Directed and randomized checks of mmap_bus_ctrl against a transaction-timed
// reference model (grant at N, bus at N+1, done at N+2, free again at N+3).
module tb_mmap_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] dbg_addr = '0, dbg_wdata = '0;
    logic        cpu_gnt, cpu_done, dbg_gnt, dbg_done;
    logic [15:0] cpu_rdata, dbg_rdata, mm_addr;
    logic        mm_re, br_stats_wr, lfsr_load;
    wire  [15:0] databus;

    logic        tb_drv_en = 1'b0;
    logic [15:0] tb_drv_val = '0;
    assign databus = tb_drv_en ? tb_drv_val : 16'hzzzz;

    mmap_bus_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
        .mm_re(mm_re), .mm_addr(mm_addr), .databus(databus),
        .br_stats_wr(br_stats_wr), .lfsr_load(lfsr_load)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one outstanding transaction described by its grant cycle.
    int          cyc;
    int          free_at;
    int          t_gnt;
    int          m_last;
    logic        m_own, m_we;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] m_rdata [2];
    logic [1:0]  m_prev_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_at    = cyc + 1;
        t_gnt      = -100;
        m_last     = 1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_prev_gnt = '0;
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        tb_drv_en = 1'b0;
        if (m_prev_gnt[0]) cpu_req = 1'b0;
        if (m_prev_gnt[1]) dbg_req = 1'b0;
    endtask

    task automatic end_cycle();
        logic [1:0]  e_gnt, e_done;
        logic        e_re, e_bsw, e_lfsr, e_oe, acc, inwin, pend, pend_own;
        logic [15:0] e_addr, e_bus, pend_val;
        int          w;
        @(negedge clk);
        e_gnt = '0; e_done = '0; e_re = 0; e_bsw = 0; e_lfsr = 0; e_oe = 0;
        e_addr = '0; e_bus = '0; pend = 0; pend_own = 0; pend_val = '0;
        acc = (cyc == t_gnt + 1);
        if (acc) begin
            e_addr = m_addr;
            inwin  = (m_addr >= 16'hC010) && (m_addr <= 16'hC016);
            if (m_we) begin
                e_oe   = 1;
                e_bus  = m_wdata;
                e_bsw  = (m_addr == 16'hC00B);
                e_lfsr = (m_addr == 16'hC016);
            end else begin
                e_re = inwin;
                if (inwin) begin
                    tb_drv_en  = 1'b1;
                    tb_drv_val = 16'($urandom);
                end
                pend     = 1;
                pend_own = m_own;
                pend_val = inwin ? tb_drv_val : 16'h0000;
            end
        end
        if (cyc == t_gnt + 2) e_done[m_own] = 1'b1;
        if (rst_n && cyc >= free_at && (cpu_req || dbg_req)) begin
            if (cpu_req && dbg_req) w = (m_last == 1) ? 0 : 1;
            else                    w = cpu_req ? 0 : 1;
            e_gnt[w] = 1'b1;
            m_own    = w[0];
            m_we     = w ? dbg_we    : cpu_we;
            m_addr   = w ? dbg_addr  : cpu_addr;
            m_wdata  = w ? dbg_wdata : cpu_wdata;
            t_gnt    = cyc;
            free_at  = cyc + 3;
            m_last   = w;
        end
        #1;
        chk("cpu_gnt", cpu_gnt, e_gnt[0]);
        chk("dbg_gnt", dbg_gnt, e_gnt[1]);
        chk("cpu_done", cpu_done, e_done[0]);
        chk("dbg_done", dbg_done, e_done[1]);
        chk("mm_re", mm_re, e_re);
        chk("mm_addr", mm_addr, e_addr);
        chk("br_stats_wr", br_stats_wr, e_bsw);
        chk("lfsr_load", lfsr_load, e_lfsr);
        chk("cpu_rdata", cpu_rdata, m_rdata[0]);
        chk("dbg_rdata", dbg_rdata, m_rdata[1]);
        chk("bus_drive", dut.w_bus_oe, e_oe);
        if (e_oe) chk("databus", databus, e_bus);
        if (pend) m_rdata[pend_own] = pend_val;
        m_prev_gnt = e_gnt;
        if (!rst_n) model_reset();
        cyc++;
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(3))
            0:       return 16'hC00B;
            1:       return 16'hC010 + 16'($urandom_range(6));
            2:       return 16'hC016;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        cyc = 0;
        model_reset();
        free_at = 0;

        // Reset state observed with rst_n still low.
        begin_cycle(); rst_n = 1'b0; end_cycle();

        // cpu read of the timer.
        begin_cycle(); rst_n = 1'b1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'hC013; cpu_wdata = 16'h1234;
        end_cycle();
        idle_cycles(3);

        // cpu write to stats enable.
        begin_cycle(); cpu_req = 1; cpu_we = 1; cpu_addr = 16'hC00B; cpu_wdata = 16'h0001;
        end_cycle();
        idle_cycles(3);

        // dbg LFSR seed, then dbg read back of the LFSR address.
        begin_cycle(); dbg_req = 1; dbg_we = 1; dbg_addr = 16'hC016; dbg_wdata = 16'h00A5;
        end_cycle();
        idle_cycles(2);
        begin_cycle(); dbg_req = 1; dbg_we = 0; dbg_addr = 16'hC016;
        end_cycle();
        idle_cycles(3);

        // Both requesters held high straight out of reset.
        begin_cycle(); rst_n = 1'b0; end_cycle();
        begin_cycle(); rst_n = 1'b1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'hC011;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'hC012;
        end_cycle();
        for (int i = 0; i < 11; i++) begin
            begin_cycle(); cpu_req = 1; dbg_req = 1; end_cycle();
        end
        begin_cycle(); cpu_req = 0; dbg_req = 0; end_cycle();
        idle_cycles(3);

        // Out-of-window read and write.
        begin_cycle(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040; end_cycle();
        idle_cycles(3);
        begin_cycle(); cpu_req = 1; cpu_we = 1; cpu_addr = 16'hC010; cpu_wdata = 16'hFFFF;
        end_cycle();
        idle_cycles(3);

        // Reset landing on the ACCESS cycle of a write.
        begin_cycle(); cpu_req = 1; cpu_we = 1; cpu_addr = 16'hC00B; cpu_wdata = 16'h0003;
        end_cycle();
        begin_cycle(); rst_n = 1'b0; end_cycle();
        begin_cycle(); rst_n = 1'b1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'hC014;
        end_cycle();
        idle_cycles(3);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            begin_cycle();
            rst_n = ($urandom_range(63) != 0);
            if (!cpu_req && $urandom_range(2) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom);
                cpu_addr = pick_addr(); cpu_wdata = 16'($urandom);
            end
            if (!dbg_req && $urandom_range(2) == 0) begin
                dbg_req = 1; dbg_we = 1'($urandom);
                dbg_addr = pick_addr(); dbg_wdata = 16'($urandom);
            end
            end_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmap_bus_ctrl.md
# mmap_bus_ctrl

Sequencer and arbiter for the memory-mapped peripheral register bank (branch-stats counters, timer, key registers, LFSR). It shares the single bank bus between two requesters, the CPU load/store port and the debug/stats-dump port. Each transaction runs through a fixed three-phase FSM that drives address, read enable, write strobes and the bidirectional databus. Read data is returned to the winning requester with a one-cycle done pulse.

## Interface
- No parameters; bus width 16, requester count fixed at 2 (index 0 = cpu, 1 = dbg).
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- cpu_req  input  1  CPU requests a bank access; held until cpu_gnt
- cpu_we  input  1  1 = write, 0 = read; sampled on the cpu_gnt cycle
- cpu_addr  input  16  target address; sampled on the cpu_gnt cycle
- cpu_wdata  input  16  write data; sampled on the cpu_gnt cycle
- cpu_gnt  output  1  one-cycle pulse; request accepted and fields latched
- cpu_done  output  1  one-cycle pulse; transaction complete, cpu_rdata valid this cycle
- cpu_rdata  output  16  read result; holds value until next done to cpu
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_rdata  same as the cpu_* ports, for the debug port
- mm_re  output  1  bank read enable
- mm_addr  output  16  bank address
- databus  inout  16  shared bank data bus; driven only during write ACCESS, else 16'hzzzz
- br_stats_wr  output  1  stats-enable write strobe (address 0xC00B)
- lfsr_load  output  1  LFSR seed load strobe (address 0xC016)

## Operation
- FSM states: IDLE, ACCESS, DONE. Transitions: IDLE→ACCESS when any req is high; ACCESS→DONE always; DONE→IDLE always.
- IDLE arbitration is round-robin over 2 requesters:
  - A single requester wins.
  - If both request, the one not granted last wins.
  - The last-granted pointer resets to dbg, so cpu wins the first contention after reset.
- Grant cycle behaviour:
  - The gnt pulse is asserted combinationally in IDLE for the winner.
  - we/addr/wdata are latched into internal registers at that edge.
  - The requester deasserts req after seeing gnt. A req still high in a later IDLE is a new transaction.
- ACCESS phase:
  - mm_addr = latched addr.
  - Read to 0xC010–0xC016: mm_re=1; databus sampled into the requester's rdata at the end of the cycle.
  - Read to any other address: mm_re=0; rdata loaded with 16'h0000.
  - Write: databus driven with latched wdata.
    - br_stats_wr=1 iff addr==0xC00B.
    - lfsr_load=1 iff addr==0xC016.
    - Writes to any other address assert no strobe and are silently dropped; rdata is unchanged.
- DONE phase: the granted requester's done pulses for one cycle. mm_re, strobes and the databus drive are inactive.
- Outside ACCESS: mm_re=0, br_stats_wr=0, lfsr_load=0, databus=z, mm_addr=0.

## Timing
- Request seen high in IDLE at cycle N:
  - gnt at N
  - ACCESS (bus active) at N+1
  - done at N+2
  - IDLE at N+3
  - Earliest next gnt at N+3.
- Throughput: one transaction per 3 cycles; fixed latency gnt→done = 2 cycles.
- Requests arriving in ACCESS or DONE wait. No gnt is issued outside IDLE.
- Simultaneous requests in IDLE: exactly one gnt. The loser keeps req high and is granted at N+3.
- Never more than one of mm_re, br_stats_wr, lfsr_load high in any cycle. Each strobe is exactly one cycle.
- Synchronous reset in any state, at the next rising edge:
  - State → IDLE, arbitration pointer → dbg.
  - All outputs → 0, both rdata → 16'h0000, databus → z.
  - An in-flight transaction is abandoned with no done pulse.
- The databus tri-state is released in the same cycle the write ACCESS ends. No drive in DONE.

## Structure
- Shared package mmap_pkg holds the items reused by the bank and by software-visible headers:
  - state enum (IDLE/ACCESS/DONE)
  - address constants ADDR_STATS_EN=16'hC00B, ADDR_BR_CNT=16'hC010 … ADDR_LFSR=16'hC016
  - read window bounds ADDR_RD_LO/ADDR_RD_HI
- One sub-module, mmap_rr_arb: a 2-way round-robin arbiter with req[1:0], an advance enable, gnt[1:0] and an internal last-grant register.
- The FSM, address decode, latches and tri-state drive live in the top module.

## Test plan
- After reset, cpu read 0xC013 (timer):
  - cpu_gnt at N, mm_re=1 with mm_addr=0xC013 at N+1, cpu_done at N+2.
  - cpu_rdata equals the databus value sampled at N+1.
- cpu write 0xC00B data 0x0001:
  - databus=0x0001 and br_stats_wr=1 for exactly cycle N+1.
  - No mm_re, no lfsr_load.
  - databus=z at N+2.
- dbg write 0xC016 data 0x00A5: lfsr_load=1 for one cycle with databus=0x00A5. A following dbg read of 0xC016 asserts mm_re at 0xC016.
- cpu_req and dbg_req both held high from reset:
  - gnt order cpu, dbg, cpu, dbg at cycles 0, 3, 6, 9.
  - Each done arrives 2 cycles after its gnt.
- Out-of-range accesses:
  - Read 0x0040: mm_re stays 0, done returns rdata 0x0000.
  - Write 0xC010 data 0xFFFF: no strobe asserted.
- rst_n low during the ACCESS cycle of a write: no done pulse next cycle, databus=z, state IDLE. A new cpu_req is granted on the first cycle after rst_n returns high.
